// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the 4-bit ALU: one command in flight, LAT-cycle wait, 2-entry response FIFO.
// Optional result checking is compiled in with `define ALU_DRV_CHECK_EN.
module alu_cmd_driver #(
  parameter int unsigned LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_op,
  output logic       rsp_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  rsp_t             rsp_buf [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             accept;
  logic             push;
  logic             pop;
  logic             mismatch_c;

  // Ready depends only on flops (and is forced low while reset is held).
  assign cmd_ready = !rst && (state == ST_IDLE) && (count < 2'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == ST_CAPTURE);
  assign pop       = rsp_valid && rsp_ready;

  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = rsp_buf[rd_ptr].data;
  assign rsp_op    = rsp_buf[rd_ptr].op;
  assign rsp_err   = rsp_buf[rd_ptr].err;

`ifdef ALU_DRV_CHECK_EN
  logic [4:0] exp5;
  logic [7:0] err_cnt_q;

  // Expected value from the latched operands; only the low result bits are compared.
  always_comb begin
    exp5       = 5'd0;
    mismatch_c = 1'b0;
    case (alu_sel)
      2'b00: begin
        exp5       = 5'(alu_a) + 5'(alu_b);
        mismatch_c = (alu_result[4:0] != exp5);
      end
      2'b01: begin
        exp5       = 5'(alu_a) - 5'(alu_b);
        mismatch_c = (alu_result[4:0] != exp5);
      end
      2'b10: begin
        exp5       = 5'(alu_a) * 5'(alu_b);
        mismatch_c = (alu_result[4:0] != exp5);
      end
      default: begin
        mismatch_c = (alu_b != 4'd0) && (alu_result[3:0] != (alu_a / alu_b));
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (push && mismatch_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign mismatch_c = 1'b0;
  assign err_cnt    = 8'd0;
`endif

  // Command FSM, operand registers and response FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_sel    <= 2'd0;
      rsp_buf[0] <= '0;
      rsp_buf[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a    <= cmd_a;
            alu_b    <= cmd_b;
            alu_sel  <= cmd_op;
            wait_cnt <= CNT_W'(LAT);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt <= CNT_W'(1)) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          rsp_buf[wr_ptr] <= '{op: alu_sel, data: alu_result, err: mismatch_c};
          wr_ptr          <= ~wr_ptr;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: directed table, reset/backpressure/latency sequences, random traffic.
module tb_alu_cmd_driver;

`ifdef ALU_DRV_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_op;
  logic       rsp_err;
  logic [7:0] err_cnt;

  logic       cmd_valid3, cmd_ready3;
  logic [1:0] cmd_op3;
  logic [3:0] cmd_a3, cmd_b3;
  logic [3:0] alu_a3, alu_b3;
  logic [1:0] alu_sel3;
  logic [7:0] alu_result3;
  logic       rsp_valid3, rsp_ready3;
  logic [7:0] rsp_data3;
  logic [1:0] rsp_op3;
  logic       rsp_err3;
  logic [7:0] err_cnt3;

  bit         fault_mode = 1'b0;
  bit         force_en   = 1'b0;
  logic [7:0] force_val  = 8'h00;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(.LAT(1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  alu_cmd_driver #(.LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .rsp_op(rsp_op3), .rsp_err(rsp_err3), .err_cnt(err_cnt3)
  );

  // Behavioural ALU: full arithmetic result, optional fault injection and override.
  function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                        input bit fault, input bit frc, input logic [7:0] fval);
    int ia, ib, r;
    logic [7:0] v;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    r = ia + ib;
      2'd1:    r = ia - ib;
      2'd2:    r = ia * ib;
      default: r = (ib == 0) ? 255 : ((ia % ib) * 16 + ia / ib);
    endcase
    v = 8'(r);
    if (fault && a == b) v = v ^ ((op == 2'd3) ? 8'h01 : 8'h10);
    if (frc) v = fval;
    return v;
  endfunction

  // Error rule: low 5 bits for add/sub/mul, low 4 bits for div, divide by zero never errs.
  function automatic bit exp_err(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input logic [7:0] d);
    int ia, ib, d5, d4;
    ia = int'(a);
    ib = int'(b);
    d5 = int'(d) % 32;
    d4 = int'(d) % 16;
    if (!CHK_ON) return 1'b0;
    case (op)
      2'd0:    return ((ia + ib) % 32) != d5;
      2'd1:    return ((ia - ib + 32) % 32) != d5;
      2'd2:    return ((ia * ib) % 32) != d5;
      default: return (ib != 0) && ((ia / ib) != d4);
    endcase
  endfunction

  assign alu_result  = alu_fn(alu_sel, alu_a, alu_b, fault_mode, force_en, force_val);
  assign alu_result3 = alu_fn(alu_sel3, alu_a3, alu_b3, 1'b0, 1'b0, 8'h00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the LAT=1 instance: predicted at accept, compared at pop.
  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    bit         err;
  } exp_t;

  exp_t        exp_q[$];
  int          err_model = 0;
  bit          prev_hold = 1'b0;
  logic [10:0] prev_rsp;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      err_model = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && rsp_valid)
        check("rsp_stable", 32'({rsp_op, rsp_data, rsp_err}), 32'(prev_rsp));
      if (cmd_valid && cmd_ready) begin
        e.op   = cmd_op;
        e.data = alu_fn(cmd_op, cmd_a, cmd_b, fault_mode, force_en, force_val);
        e.err  = exp_err(cmd_op, cmd_a, cmd_b, e.data);
        exp_q.push_back(e);
        if (e.err && err_model < 255) err_model++;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_pop", 32'({rsp_op, rsp_data, rsp_err}), 32'({e.op, e.data, e.err}));
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = {rsp_op, rsp_data, rsp_err};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for cmd_ready, let the accept edge pass, then drop cmd_valid.
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(cmd_ready), 32'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    wait_accept();
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    bit         frc;
    logic [7:0] fval;
    logic [7:0] exp_data;
    bit         err_if_chk;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, tbl_errs, seen, n_acc, last_acc;
    int acc_q[$];

    tbl[0]  = '{2'd0, 4'd9,  4'd8,  1'b0, 8'h00, 8'h11, 1'b0};
    tbl[1]  = '{2'd1, 4'd3,  4'd5,  1'b0, 8'h00, 8'hFE, 1'b0};
    tbl[2]  = '{2'd2, 4'd7,  4'd5,  1'b1, 8'h00, 8'h00, 1'b1};
    tbl[3]  = '{2'd2, 4'd7,  4'd5,  1'b1, 8'h03, 8'h03, 1'b0};
    tbl[4]  = '{2'd3, 4'd6,  4'd0,  1'b0, 8'h00, 8'hFF, 1'b0};
    tbl[5]  = '{2'd3, 4'd6,  4'd0,  1'b1, 8'h5A, 8'h5A, 1'b0};
    tbl[6]  = '{2'd3, 4'd15, 4'd4,  1'b0, 8'h00, 8'h33, 1'b0};
    tbl[7]  = '{2'd2, 4'd15, 4'd15, 1'b0, 8'h00, 8'hE1, 1'b0};
    tbl[8]  = '{2'd1, 4'd0,  4'd15, 1'b0, 8'h00, 8'hF1, 1'b0};
    tbl[9]  = '{2'd3, 4'd9,  4'd3,  1'b1, 8'h02, 8'h02, 1'b1};
    tbl[10] = '{2'd0, 4'd15, 4'd15, 1'b0, 8'h00, 8'h1E, 1'b0};
    tbl[11] = '{2'd2, 4'd7,  4'd5,  1'b0, 8'h00, 8'h23, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 4'd0; cmd_b = 4'd0; rsp_ready = 1'b0;
    cmd_valid3 = 1'b0; cmd_op3 = 2'd0; cmd_a3 = 4'd0; cmd_b3 = 4'd0; rsp_ready3 = 1'b0;
    repeat (3) tick();
    check("rst_outputs", 32'({alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_op, rsp_err, err_cnt}), 32'(0));
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(cmd_ready), 32'(1));
    tick();

    // Reset while the command is waiting on the ALU.
    send(2'd0, 4'd3, 4'd4);
    check("midrst_alu_pins", 32'({alu_a, alu_b, alu_sel}), 32'({4'd3, 4'd4, 2'd0}));
    rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_op, rsp_err, err_cnt}), 32'(0));
    check("midrst_cmd_ready", 32'(cmd_ready), 32'(0));
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", 32'(cmd_ready), 32'(1));
    seen = 0;
    repeat (6) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    check("midrst_no_rsp", 32'(seen), 32'(0));

    // Directed single-command table on LAT=1.
    tbl_errs = 0;
    foreach (tbl[i]) begin
      force_en  = tbl[i].frc;
      force_val = tbl[i].fval;
      send(tbl[i].op, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d_alu_pins", i), 32'({alu_a, alu_b, alu_sel}),
            32'({tbl[i].a, tbl[i].b, tbl[i].op}));
      edges = 0;
      while (!rsp_valid && edges < 20) begin
        tick();
        edges++;
      end
      check($sformatf("tbl%0d_latency", i), 32'(edges), 32'(2));
      check($sformatf("tbl%0d_rsp", i), 32'({rsp_op, rsp_data, rsp_err}),
            32'({tbl[i].op, tbl[i].exp_data, tbl[i].err_if_chk & CHK_ON}));
      if (tbl[i].err_if_chk & CHK_ON) tbl_errs++;
      check($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt), 32'(tbl_errs));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      force_en  = 1'b0;
    end

    // Backpressure: two buffered responses block the third command.
    send(2'd0, 4'd1, 4'd2);
    send(2'd1, 4'd5, 4'd3);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 4'd2; cmd_b = 4'd3;
    repeat (6) tick();
    check("bp_ready_blocked", 32'(cmd_ready), 32'(0));
    check("bp_head", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'h03}));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_head_after_pop", 32'(rsp_data), 32'(8'h02));
    wait_accept();
    repeat (4) tick();
    rsp_ready = 1'b1;
    repeat (4) tick();
    rsp_ready = 1'b0;
    check("bp_drained", 32'(exp_q.size()), 32'(0));

    // Random traffic with fault injection on equal operands.
    fault_mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(9) < 6);
      cmd_op    = 2'($urandom);
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      rsp_ready = 1'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) tick();
    rsp_ready  = 1'b0;
    fault_mode = 1'b0;
    check("rand_drain_empty", 32'(exp_q.size()), 32'(0));
    check("rand_err_cnt", 32'(err_cnt), 32'(err_model));

    // LAT=3 throughput: held valid/ready gives one accept every 5 cycles.
    cmd_valid3 = 1'b1; cmd_op3 = 2'd0; cmd_a3 = 4'd2; cmd_b3 = 4'd5; rsp_ready3 = 1'b1;
    n_acc = 0;
    last_acc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid3) begin
        if (acc_q.size() == 0) begin
          check("lat3_unexpected_rsp", 32'(rsp_valid3), 32'(0));
        end else begin
          check("lat3_delay", 32'(c - acc_q.pop_front()), 32'(4));
          check("lat3_data", 32'({rsp_op3, rsp_data3}), 32'({2'd0, 8'd7}));
        end
      end
      if (cmd_valid3 && cmd_ready3) begin
        if (last_acc >= 0) check("lat3_gap", 32'(c + 1 - last_acc), 32'(5));
        last_acc = c + 1;
        acc_q.push_back(c + 1);
        n_acc++;
      end
    end
    check("lat3_accept_count", 32'(n_acc >= 7), 32'(1));
    cmd_valid3 = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side initiator for the 4-bit ALU datapath.
- Accepts operand/opcode commands over a valid/ready handshake and drives the ALU operand and select pins.
- Waits out the ALU's registered latency, captures the 8-bit result and returns it through a 2-entry response buffer with valid/ready backpressure.
- Sits between a host/test controller and the ALU; keeps at most one command in flight.

## Interface
- LAT, default 1: ALU result latency in clock edges after the operand pins change; legal range 1–15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- alu_a  out  4  registered operand A to ALU.
- alu_b  out  4  registered operand B to ALU.
- alu_sel  out  2  registered opcode to ALU.
- alu_result  in  8  ALU result bus.
- rsp_valid  out  1  response available (head of buffer).
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_data  out  8  captured alu_result.
- rsp_op  out  2  opcode of the response.
- rsp_err  out  1  check mismatch flag; 0 when checking is compiled out.
- err_cnt  out  8  saturating mismatch count; 0 when checking is compiled out.

## Operation
- FSM states:
  - IDLE: cmd_ready = (buffer count < 2). On accept, latch cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_sel and go to WAIT with wait counter = LAT.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to CAPTURE.
  - CAPTURE: sample alu_result and push {op, data, err} into the buffer, then return to IDLE.
- cmd_ready is 0 in WAIT and CAPTURE.
- Between commands, alu_a/alu_b/alu_sel hold their last values.
- Response buffer: 2-entry FIFO with in-order pop.
  - A command is accepted only when count < 2. Since only one command is in flight, the CAPTURE push never finds the buffer full.
  - Simultaneous push and pop: count unchanged, order preserved.
  - rsp_data/rsp_op/rsp_err are stable while rsp_valid && !rsp_ready.
- Reset (any state, mid-command included):
  - The in-flight command is dropped and the buffer is emptied.
  - FSM goes to IDLE.
  - alu_a = 0, alu_b = 0, alu_sel = 0, rsp_valid = 0, rsp_data = 0, rsp_op = 0, rsp_err = 0, err_cnt = 0.
  - cmd_ready = 0 while rst is high.

## Timing
- Command accepted at edge N.
- New alu_a/alu_b/alu_sel are visible after edge N.
- alu_result is sampled at edge N+1+LAT.
- rsp_valid is high after edge N+1+LAT (if the buffer was empty).
- cmd_ready is high again in the cycle after the capture edge.
- Maximum throughput: one command per LAT+2 cycles.
- After rst deasserts, cmd_ready is 1 in the first cycle.

## Configuration
- Macro ALU_DRV_CHECK_EN.
- Defined:
  - On capture, compute the expected value from the latched operands:
    - add/sub/mul: compare alu_result[4:0] with the low 5 bits of a+b, a−b or a*b.
    - div: compare alu_result[3:0] with a/b. When b = 0, the comparison is skipped and counts as a pass.
  - Mismatch sets rsp_err in that entry and increments err_cnt, saturating at 255.
- Undefined: no comparator logic; rsp_err and err_cnt are tied to 0. Ports remain present.

## Test plan
- Reset mid-command: accept add 3+4, assert rst during WAIT → all outputs 0, no response ever appears. After release, cmd_ready = 1 on the next cycle.
- Basic add, LAT=1: a=9, b=8, op=00 accepted at edge N → alu_a=9, alu_b=8, alu_sel=0 after N; rsp_valid after N+2 with rsp_data[4:0]=17, rsp_op=0, rsp_err=0.
- Backpressure: rsp_ready=0, issue three commands back-to-back.
  - Two responses are buffered, then cmd_ready stays 0.
  - Pulse rsp_ready for one cycle → cmd_ready returns and the third command is accepted.
  - Responses pop in issue order.
- Check (macro on): bench ALU model corrupts mul 7*5 to return 0x00 → rsp_err=1 and err_cnt=1. The correct return 0x03 gives rsp_err=0.
- Divide by zero (macro on): op=11, a=6, b=0, any alu_result → rsp_err=0, err_cnt unchanged.
- Latency parameter: LAT=3, cmd_valid held high with rsp_ready=1 → one accept every 5 cycles; each rsp_valid arrives 4 edges after its accept.
